// File: rtl/s_mem_arbiter_if.sv
// Requester-side bus of the S-memory arbiter: packed per-requester requests in,
// one-hot grant and tagged read return out.
interface s_mem_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ-1:0]        req_wren;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;

    modport master (
        output req, lock, req_wren, req_addr, req_data,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, req_wren, req_addr, req_data,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/s_mem_arbiter.sv
// Round-robin request/grant arbiter sharing one single-port S-memory between
// several requester FSMs, with lock for atomic swaps and tagged read return.
module s_mem_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stop,
    s_mem_arbiter_if.slave    bus,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              mem_rden,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic {IDLE, OWNED} state_t;

    state_t            state_q, state_d;
    idx_t              owner_q, owner_d;
    idx_t              ptr_q, ptr_d;
    logic [IDX_W:0]    pick;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              tag_valid_q [RD_LATENCY];
    idx_t              tag_idx_q   [RD_LATENCY];

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];
    logic              access;
    logic              owner_wren;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
        assign data_arr[g] = bus.req_data[g*DATA_W +: DATA_W];
    end

    function automatic idx_t wrap_inc(input idx_t i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + idx_t'(1);
    endfunction

    // Returns {found, index} of the first set request at or after start, wrapping.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r, input idx_t start);
        logic found;
        idx_t idx;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int j;
            j = int'(start) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && r[idx_t'(j)]) begin
                found = 1'b1;
                idx   = idx_t'(j);
            end
        end
        return {found, idx};
    endfunction

    assign access     = (state_q == OWNED) && bus.req[owner_q] && !stop;
    assign owner_wren = bus.req_wren[owner_q];

    // NOTE: every signal written in a combinational block gets a default first,
    // so no path through the case/if tree can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        pick    = '0;
        if (!stop) begin
            case (state_q)
                IDLE: begin
                    pick = rr_pick(bus.req, ptr_q);
                    if (pick[IDX_W]) begin
                        state_d = OWNED;
                        owner_d = pick[IDX_W-1:0];
                    end
                end
                OWNED: begin
                    // Unlocked owner: search restarts just past it, so it parks only if alone.
                    if (!bus.lock[owner_q]) begin
                        ptr_d = wrap_inc(owner_q);
                        pick  = rr_pick(bus.req, ptr_d);
                        if (pick[IDX_W]) owner_d = pick[IDX_W-1:0];
                        else             state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            if (access) begin
                addr_q <= addr_arr[owner_q];
                data_q <= data_arr[owner_q];
            end
        end
    end

    // NOTE: the tag pipeline is reset, unlike a data RAM, because a stale valid
    // bit would fire a spurious rvalid after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_valid_q[i] <= 1'b0;
                tag_idx_q[i]   <= '0;
            end
        end else begin
            tag_valid_q[0] <= access && !owner_wren;
            tag_idx_q[0]   <= owner_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_idx_q[i]   <= tag_idx_q[i-1];
            end
        end
    end

    always_comb begin
        bus.gnt = '0;
        if (state_q == OWNED) bus.gnt[owner_q] = 1'b1;
        bus.rvalid = '0;
        if (tag_valid_q[RD_LATENCY-1]) bus.rvalid[tag_idx_q[RD_LATENCY-1]] = 1'b1;
    end

    assign bus.rdata   = mem_q;
    assign mem_wren    = access && owner_wren;
    assign mem_rden    = access && !owner_wren;
    assign mem_address = access ? addr_arr[owner_q] : addr_q;
    assign mem_data    = access ? data_arr[owner_q] : data_q;

endmodule

// File: doc/s_mem_arbiter.md
Name: s_mem_arbiter

Overview:
- Shares one single-port S-memory (256x8) between NUM_REQ requester FSMs: initialize, shuffle and decrypt.
- Replaces completion-flag-driven muxing with request/grant arbitration, so FSM phases may overlap or repeat without mux glue.
- Supports lock for atomic read-modify-write swap sequences.
- Returns read data tagged to the issuing requester.

Parameters:
- NUM_REQ, 3, number of requesters (index 0 = highest priority after reset).
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.
- RD_LATENCY, 1, cycles from rden-high edge to valid mem_q (1..3).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- stop  in  1  freeze: no new grants, no new memory accesses
- req  in  NUM_REQ  per-requester access request
- lock  in  NUM_REQ  owner keeps grant across accesses while high
- req_wren  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  packed write data
- gnt  out  NUM_REQ  one-hot grant (registered)
- rvalid  out  NUM_REQ  one-cycle read-data-valid pulse per requester
- rdata  out  DATA_W  read data, equal to mem_q
- mem_address  out  ADDR_W  to S-memory
- mem_data  out  DATA_W  to S-memory
- mem_wren  out  1  to S-memory
- mem_rden  out  1  to S-memory
- mem_q  in  DATA_W  from S-memory

Behaviour:
- Reset (async, reset_n low):
  - gnt = 0, rvalid = 0, read-tag pipeline cleared.
  - Round-robin pointer = 0.
  - mem_wren = mem_rden = 0; mem_address = mem_data = 0.
- States:
  - IDLE: no owner.
  - OWNED: owner k, gnt[k] = 1.
- IDLE -> OWNED(k):
  - Taken on the clock edge when stop = 0 and any req is high.
  - k = first requester with req high, searching from the pointer upward with wrap (pointer 0 -> order 0,1,2).
  - gnt[k] asserts the cycle after req is first seen. Minimum grant latency is 1 cycle.
- Access rule:
  - An access occurs in a cycle iff gnt[k] & req[k] & ~stop.
  - mem_address = req_addr[k] and mem_data = req_data[k] (combinational from owner).
  - mem_wren = req_wren[k]; mem_rden = ~req_wren[k].
  - With no access, mem_wren = mem_rden = 0 and address/data hold their last value.
- Release and handoff:
  - Grant is kept while req[k] & lock[k].
  - With lock[k] low, after an access the grant rotates if any other req is high. Pointer becomes k+1 mod NUM_REQ; the new owner is granted next edge (no idle cycle).
  - With lock[k] low and no other requester pending, the grant parks on k.
  - req[k] low and lock[k] low -> IDLE, or direct handoff if another req is high.
  - req[k] low with lock[k] high: grant held, no access (owner stall).
- Read return:
  - Each read access pushes owner index k into a RD_LATENCY-deep tag pipeline.
  - rvalid[k] pulses exactly RD_LATENCY cycles after the access cycle; rdata = mem_q in that cycle.
  - Tags survive grant changes and stop.
- Write-then-read to the same address in consecutive cycles returns the new value (memory is read-during-write new-data at these latencies).
- stop:
  - Blocks new grants and accesses; the current owner keeps gnt.
  - In-flight read tags still drain.
  - Deassert resumes with no lost or duplicated access.
- Simultaneous events:
  - Owner release and other requests in the same cycle: round-robin from k+1.
  - Only when pointer-relative order ties does the lowest index win.
- Reset mid-operation clears everything immediately. In-flight reads produce no rvalid.

Test Plan:
- Reset then req = 3'b111, lock = 0, all reads -> gnt order 001, 010, 100, 001 on successive cycles; each rvalid pulses 1 cycle after its access (RD_LATENCY = 1).
- Requester 1 holds lock, performs read addr 5, read addr 9, write addr 5 = 0x9, write addr 9 = old[5], while req[0] and req[2] are high -> gnt stays 010 for all 4 accesses, then moves to 100.
- Single requester 2, lock = 0, 10 back-to-back reads -> gnt parks at 100, 10 consecutive rvalid[2] pulses with rdata = mem contents of addresses 0..9.
- stop pulsed for 3 cycles mid-stream with a read in flight -> pending rvalid still fires, mem_rden = 0 for 3 cycles, access sequence resumes unchanged.
- reset_n asserted while read in flight with RD_LATENCY = 2 -> no rvalid, gnt = 0 immediately; after release, pointer restarts at requester 0.
